// File: rtl/wb_text_console_pkg.sv
// wb_text_console_pkg: bus region/register map, cursor row, intensity levels and IRGB colour expansion.
package wb_text_console_pkg;
  localparam logic [1:0] RGN_CHAR = 2'b00;
  localparam logic [1:0] RGN_ATTR = 2'b01;
  localparam logic [1:0] RGN_REGS = 2'b10;
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_CUR_X = 3'd1;
  localparam logic [2:0] REG_CUR_Y = 3'd2;
  localparam logic [2:0] REG_SCROLL = 3'd3;
  localparam logic [2:0] REG_FRAME = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam int CTRL_DISP = 0;
  localparam int CTRL_CUR = 1;
  localparam int CTRL_BLINK = 2;
  localparam logic [2:0] CUR_ROW_FIRST = 3'd6;
  localparam logic [7:0] LVL_FULL = 8'hFF;
  localparam logic [7:0] LVL_HI = 8'hAA;
  localparam logic [7:0] LVL_LO = 8'h55;
  localparam logic [7:0] LVL_OFF = 8'h00;
  typedef struct packed {
    logic vis;
    logic cur;
    logic hide;
    logic blink;
    logic [2:0] bit_idx;
    logic [2:0] fr;
  } vid_t;
  function automatic logic [7:0] level(input logic c, input logic i);
    return c ? (i ? LVL_FULL : LVL_HI) : (i ? LVL_LO : LVL_OFF);
  endfunction
  function automatic logic [23:0] irgb_to_rgb(input logic [3:0] irgb);
    return {level(irgb[2], irgb[3]), level(irgb[1], irgb[3]), level(irgb[0], irgb[3])};
  endfunction
endpackage

// File: rtl/font_rom_8x8.sv
// font_rom_8x8: registered 8x8 glyph lookup ('A', 'B' and full block 0xDB; other codes blank), MSB is leftmost pixel.
module font_rom_8x8 (
  input  logic       clk,
  input  logic [7:0] ch,
  input  logic [2:0] row,
  output logic [7:0] bits
);
  logic [63:0] g;
  always_comb g = ch == 8'h41 ? 64'h183C66667E666600 :
                  ch == 8'h42 ? 64'h7C66667C66667C00 :
                  ch == 8'hDB ? {64{1'b1}} : 64'h0;
  always_ff @(posedge clk) bits <= g[{~row, 3'b000} +: 8];
endmodule

// File: rtl/text_cell_ram.sv
// text_cell_ram: dual-port cell store {attr, char}; port A video read, port B bus read/write with byte enables.
module text_cell_ram #(
  parameter int DEPTH = 2400,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  output logic [15:0]   q_a,
  input  logic          en_b,
  input  logic [1:0]    we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [15:0]   d_b,
  output logic [15:0]   q_b
);
  logic [15:0] mem [DEPTH];
  // read-before-write: a same-cycle video read of a cell being written sees the old contents
  always_ff @(posedge clk) begin
    q_a <= mem[addr_a];
    if (en_b) q_b <= mem[addr_b];
    if (we_b[0]) mem[addr_b][7:0] <= d_b[7:0];
    if (we_b[1]) mem[addr_b][15:8] <= d_b[15:8];
  end
endmodule

// File: rtl/wb_text_console.sv
// wb_text_console: Wishbone-mapped text-mode controller with scroll, cursor and blink; 4-clk pixel pipeline.
module wb_text_console
  import wb_text_console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int V_SCALE = 2,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [7:0]        wb_dat_i,
  output logic [7:0]        wb_dat_o,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  output logic              wb_ack_o,
  input  logic              video_active,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW = $clog2(CELLS + 1);
  localparam int OW = ADDR_W - 2;
  localparam int VS = $clog2(V_SCALE);
  localparam logic [OW:0] CELL_END = CELLS[OW:0];
  localparam logic [10:0] X_END = 11'(COLS * 8);
  localparam logic [10:0] Y_END = 11'(ROWS * 8 * V_SCALE);
  localparam logic [10:0] ROWS_W = 11'(ROWS);
  logic [1:0] region;
  logic [OW-1:0] off;
  logic req, cell_ok, rd_ram, rd_attr, en_b, in_area, cur_hit, on;
  logic [2:0] ctrl, fr;
  logic [7:0] cur_x, cur_y, scroll, frame, reg_val, reg_q, attr_q, glyph;
  logic [15:0] q_a, q_b;
  logic [9:0] sy;
  logic [10:0] row_sum, ram_row;
  logic [AW-1:0] addr_v, addr_q;
  logic [23:0] fg, bg, pix;
  vid_t s0, s1, s2;
  assign region = wb_adr_i[ADDR_W-1 -: 2];
  assign off = wb_adr_i[OW-1:0];
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign cell_ok = {1'b0, off} < CELL_END;
  assign en_b = req & ~region[1] & cell_ok;
  assign wb_dat_o = rd_ram ? (rd_attr ? q_b[15:8] : q_b[7:0]) : reg_q;
  always_comb reg_val = off[2:0] == REG_CTRL   ? {5'b0, ctrl} :
                        off[2:0] == REG_CUR_X  ? cur_x :
                        off[2:0] == REG_CUR_Y  ? cur_y :
                        off[2:0] == REG_SCROLL ? scroll :
                        off[2:0] == REG_FRAME  ? frame :
                        off[2:0] == REG_STATUS ? {7'b0, ~video_active} : 8'h00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= 3'b001;
      cur_x <= '0;
      cur_y <= '0;
      scroll <= '0;
      frame <= '0;
      wb_ack_o <= 1'b0;
      rd_ram <= 1'b0;
      rd_attr <= 1'b0;
      reg_q <= '0;
    end else begin
      wb_ack_o <= req;
      if (video_active && pixel_x == 10'd0 && pixel_y == 10'd0) frame <= frame + 8'd1;
      if (req) begin
        rd_ram <= ~region[1] & cell_ok;
        rd_attr <= region == RGN_ATTR;
        reg_q <= region == RGN_REGS ? reg_val : 8'h00;
      end
      if (req && wb_we_i && region == RGN_REGS) begin
        if (off[2:0] == REG_CTRL) ctrl <= wb_dat_i[2:0];
        if (off[2:0] == REG_CUR_X) cur_x <= wb_dat_i;
        if (off[2:0] == REG_CUR_Y) cur_y <= wb_dat_i;
        if (off[2:0] == REG_SCROLL && {3'b0, wb_dat_i} < ROWS_W) scroll <= wb_dat_i;
      end
    end
  end
  text_cell_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .clk(clk),
    .addr_a(addr_q),
    .q_a(q_a),
    .en_b(en_b),
    .we_b({2{en_b & wb_we_i}} & {region == RGN_ATTR, region == RGN_CHAR}),
    .addr_b(off[AW-1:0]),
    .d_b({2{wb_dat_i}}),
    .q_b(q_b)
  );
  font_rom_8x8 u_font (
    .clk(clk),
    .ch(q_a[7:0]),
    .row(s1.fr),
    .bits(glyph)
  );
  // scroll wrap: sy < ROWS and scroll < ROWS, so one conditional subtract suffices
  always_comb begin
    sy = pixel_y >> (3 + VS);
    fr = pixel_y[VS+2:VS];
    in_area = {1'b0, pixel_x} < X_END && {1'b0, pixel_y} < Y_END;
    row_sum = {1'b0, sy} + {3'b0, scroll};
    ram_row = row_sum >= ROWS_W ? row_sum - ROWS_W : row_sum;
    addr_v = AW'(ram_row) * AW'(COLS) + AW'(pixel_x[9:3]);
    cur_hit = ctrl[CTRL_CUR] && {1'b0, pixel_x[9:3]} == cur_x && sy == {2'b0, cur_y} &&
              fr >= CUR_ROW_FIRST && !(ctrl[CTRL_BLINK] && frame[4]);
  end
  always_comb begin
    on = (glyph[~s2.bit_idx] && !(s2.hide && attr_q[7])) || s2.cur;
    fg = irgb_to_rgb(attr_q[3:0]);
    bg = irgb_to_rgb({attr_q[7] & ~s2.blink, attr_q[6:4]});
    pix = s2.vis ? (on ? fg : bg) : 24'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      addr_q <= '0;
      attr_q <= '0;
      {red, green, blue} <= '0;
    end else begin
      s0 <= '{vis: video_active & in_area & ctrl[CTRL_DISP], cur: cur_hit,
              hide: ctrl[CTRL_BLINK] & frame[5], blink: ctrl[CTRL_BLINK],
              bit_idx: pixel_x[2:0], fr: fr};
      addr_q <= addr_v;
      s1 <= s0;
      s2 <= s1;
      attr_q <= q_a[15:8];
      {red, green, blue} <= pix;
    end
  end
endmodule

// File: tb/tb_wb_text_console.sv
// tb_wb_text_console: directed vector table plus hand sequences for scroll, cursor, blink and bus corners.
module tb_wb_text_console;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [13:0] wb_adr_i = '0;
  logic [7:0] wb_dat_i = '0, wb_dat_o, red, green, blue;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic video_active = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  int checks = 0, errors = 0;
  logic [7:0] frame_exp = '0;
  localparam logic [23:0] WHITE = 24'hFFFFFF, BLUE = 24'h0000AA, BLACK = 24'h0, GREY = 24'h555555;
  localparam logic [13:0] A_CHAR = 14'h0000, A_ATTR = 14'h1000, A_REGS = 14'h2000;
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [23:0] rgb;
  } vec_t;
  vec_t v[14];

  wb_text_console dut (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .video_active(video_active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wb_write(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [13:0] a, input string name, input logic [7:0] exp);
    @(negedge clk);
    wb_adr_i = a; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge clk);
    check({name, "_ack"}, 24'(wb_ack_o), 24'd1);
    check(name, 24'(wb_dat_o), 24'(exp));
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  // one active pixel, then idle; result appears after the 4th rising edge
  task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic [23:0] got, output logic [23:0] early);
    @(negedge clk);
    pixel_x = x; pixel_y = y; video_active = 1'b1;
    @(negedge clk);
    video_active = 1'b0; pixel_x = '0; pixel_y = '0;
    @(negedge clk);
    @(negedge clk);
    early = {red, green, blue};
    @(negedge clk);
    got = {red, green, blue};
    if (x == 10'd0 && y == 10'd0) frame_exp++;
  endtask

  task automatic pchk(input string name, input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp);
    logic [23:0] got, early;
    probe(x, y, got, early);
    check(name, got, exp);
  endtask

  task automatic goto_frame(input logic [7:0] t);
    logic [7:0] n;
    n = t - frame_exp;
    if (n != 8'd0) begin
      @(negedge clk);
      pixel_x = '0; pixel_y = '0; video_active = 1'b1;
      repeat (int'(n)) @(negedge clk);
      video_active = 1'b0;
      frame_exp = t;
    end
  endtask

  initial begin
    logic [23:0] got, early;
    logic [7:0] row_b;
    v[0] = '{10'd0, 10'd0, BLUE};    v[1] = '{10'd1, 10'd0, BLUE};
    v[2] = '{10'd2, 10'd0, BLUE};    v[3] = '{10'd3, 10'd0, WHITE};
    v[4] = '{10'd4, 10'd0, WHITE};   v[5] = '{10'd5, 10'd0, BLUE};
    v[6] = '{10'd6, 10'd0, BLUE};    v[7] = '{10'd7, 10'd0, BLUE};
    v[8] = '{10'd3, 10'd1, WHITE};   v[9] = '{10'd2, 10'd2, WHITE};
    v[10] = '{10'd1, 10'd2, BLUE};   v[11] = '{10'd6, 10'd4, WHITE};
    v[12] = '{10'd640, 10'd0, BLACK}; v[13] = '{10'd3, 10'd480, BLACK};
    repeat (3) @(negedge clk);
    check("reset_rgb", {red, green, blue}, BLACK);
    check("reset_ack", 24'(wb_ack_o), 24'd0);
    check("reset_dat", 24'(wb_dat_o), 24'd0);
    rst_n = 1'b1;
    wb_read(A_REGS + 14'd4, "frame_reset", 8'h00);
    wb_read(A_REGS + 14'd0, "ctrl_reset", 8'h01);
    wb_write(A_CHAR, 8'h41);
    wb_write(A_ATTR, 8'h1F);
    wb_read(A_CHAR, "char_rb", 8'h41);
    wb_read(A_ATTR, "attr_rb", 8'h1F);
    probe(10'd3, 10'd0, got, early);
    check("latency_early", early, BLACK);
    check("latency_on_time", got, WHITE);
    for (int i = 0; i < 14; i++) begin
      probe(v[i].x, v[i].y, got, early);
      check($sformatf("vec%0d", i), got, v[i].rgb);
    end
    // scroll by one row: RAM row 1 ('B') appears on screen row 0
    wb_write(A_CHAR + 14'd80, 8'h42);
    wb_write(A_ATTR + 14'd80, 8'h1F);
    wb_write(A_REGS + 14'd3, 8'd1);
    row_b = 8'h7C;
    for (int x = 1; x < 8; x++) pchk($sformatf("scroll_x%0d", x), 10'(x), 10'd0, row_b[7-x] ? WHITE : BLUE);
    pchk("scroll_wrap", 10'd3, 10'd464, WHITE);
    wb_write(A_REGS + 14'd3, 8'd30);
    wb_read(A_REGS + 14'd3, "scroll_ignore", 8'd1);
    wb_write(A_REGS + 14'd3, 8'd0);
    // cursor at cell (3,2) over a blank cell
    wb_write(A_CHAR + 14'd163, 8'h20);
    wb_write(A_ATTR + 14'd163, 8'h1F);
    wb_write(A_REGS + 14'd1, 8'd3);
    wb_write(A_REGS + 14'd2, 8'd2);
    wb_write(A_REGS + 14'd0, 8'h03);
    pchk("cursor_row6", 10'd24, 10'd44, WHITE);
    pchk("cursor_row7", 10'd31, 10'd47, WHITE);
    pchk("cursor_row5", 10'd24, 10'd43, BLUE);
    pchk("cursor_row0", 10'd28, 10'd32, BLUE);
    wb_write(A_REGS + 14'd0, 8'h07);
    goto_frame(8'd16);
    pchk("cursor_blink_off", 10'd24, 10'd44, BLUE);
    goto_frame(8'd32);
    pchk("cursor_blink_on", 10'd24, 10'd44, WHITE);
    // blinking full-block cell
    wb_write(A_CHAR, 8'hDB);
    wb_write(A_ATTR, 8'h8F);
    wb_write(A_REGS + 14'd0, 8'h05);
    pchk("blink_f32", 10'd1, 10'd0, BLACK);
    goto_frame(8'd64);
    pchk("blink_f64", 10'd1, 10'd0, WHITE);
    goto_frame(8'd95);
    pchk("blink_f95", 10'd1, 10'd0, WHITE);
    goto_frame(8'd96);
    pchk("blink_f96", 10'd1, 10'd0, BLACK);
    wb_read(A_REGS + 14'd4, "frame_count", frame_exp);
    wb_write(A_CHAR, 8'h20);
    wb_write(A_REGS + 14'd0, 8'h01);
    pchk("bg_intensity", 10'd1, 10'd0, GREY);
    wb_write(A_REGS + 14'd0, 8'h05);
    pchk("bg_no_intensity", 10'd1, 10'd0, BLACK);
    wb_write(A_REGS + 14'd0, 8'h00);
    pchk("display_off", 10'd1, 10'd0, BLACK);
    wb_read(A_REGS + 14'd5, "status_blank", 8'h01);
    wb_read(14'd2400, "oob_read", 8'h00);
    // held strobe acks every other cycle
    @(negedge clk);
    wb_adr_i = A_REGS; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("held_ack%0d", i), 24'(wb_ack_o), (i % 2 == 0) ? 24'd1 : 24'd0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    // asynchronous reset in the middle of a transfer
    @(negedge clk);
    wb_adr_i = A_REGS; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_ack", 24'(wb_ack_o), 24'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ack", 24'(wb_ack_o), 24'd0);
    check("async_reset_dat", 24'(wb_dat_o), 24'd0);
    check("async_reset_rgb", {red, green, blue}, BLACK);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(A_REGS, "ctrl_after_reset", 8'h01);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_text_console.md
# wb_text_console

Parametrised text-mode video controller: a COLS×ROWS grid of 8×8 character cells with V_SCALE vertical pixel replication. Adds hardware row scroll, a blinking underline cursor, a per-cell blink attribute and a memory-mapped control register bank to the fixed 80×30 text mode. Sits between the Wishbone bus and the HDMI encoder RGB inputs, and is driven by the `hdmi_timing` pixel counters. Bus and video share one clock.

## Interface
- `COLS`, 80, character columns (1–128)
- `ROWS`, 30, character rows (1–64)
- `V_SCALE`, 2, vertical replication factor (1, 2 or 4)
- `ADDR_W`, 14, Wishbone address width
  - `[ADDR_W-1:ADDR_W-2]` selects the region: 00 char, 01 attr, 10 regs, 11 reserved.
- `clk` in 1: single system/pixel clock
- `rst_n` in 1: asynchronous, active-low reset
- `wb_adr_i` in ADDR_W: Wishbone address
- `wb_dat_i` in 8: write data
- `wb_dat_o` out 8: read data, valid with ack
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1: Wishbone cycle, strobe and write enable
- `wb_ack_o` out 1: Wishbone acknowledge
- `video_active` in 1: inside the visible area
- `pixel_x`, `pixel_y` in 10: current pixel coordinates
- `red`, `green`, `blue` out 8: pixel colour

## Operation
**Cell address.** Region offset `off` = `wb_adr_i[ADDR_W-3:0]`. Cells with `off < COLS*ROWS` are row-major. Writes outside that range are ignored; reads return 0.

**Registers** (regs region, `off[2:0]`; other offsets read 0 and ignore writes):
- 0 CTRL: bit0 display_en, bit1 cursor_en, bit2 blink_en. Reset 0x01.
- 1 CUR_X, 2 CUR_Y: cursor cell, stored raw. Reset 0.
- 3 SCROLL: top displayed RAM row. A write with value ≥ ROWS is ignored. Reset 0.
- 4 FRAME: read-only 8-bit frame counter.
- 5 STATUS: read-only; bit0 = !video_active.

**Text area.**
- pixel_x < COLS*8 and pixel_y < ROWS*8*V_SCALE.
- Column cx = pixel_x/8, screen row sy = pixel_y/(8*V_SCALE), font row fr = (pixel_y/V_SCALE) mod 8.
- RAM row = (sy + SCROLL) mod ROWS, computed as a single conditional subtract with no divider.

**Pixel colour.**
- Attribute byte: [3:0] fg IRGB, [6:4] bg RGB, [7] bg intensity or blink.
- When blink_en = 1: bit7 means blink and the bg intensity is 0. A blinking cell shows bg only when FRAME[5] = 1.
- Cursor: cursor_en, cell equals (CUR_X, CUR_Y) in screen coordinates, and fr ∈ {6,7}. If blink_en is set, FRAME[4] must also be 0. Cursor pixels use the fg colour.
- IRGB to 8-bit per channel: c & I → FF, c & !I → AA, !c & I → 55, else 00.
- Outside the text area, or with display_en = 0, or with video_active = 0: output 000000.

**Frame counter.** FRAME increments (mod 256) on the cycle where video_active = 1, pixel_x = 0 and pixel_y = 0.

## Timing
- Video pipeline has a fixed latency of 4 clk from the inputs to RGB:
  - S0: register cell address, fr and bit index.
  - S1: cell RAM read.
  - S2: font ROM read.
  - S3: colour mux and register.
- video_active and the in-area flag are delayed alongside, so output alignment is exact.
- Register values are sampled at S0. A mid-frame write takes effect 4 clk later, with no tearing protection.
- Wishbone:
  - `wb_ack_o` asserts the cycle after cyc&stb, for one cycle only.
  - A held strobe acks every other cycle.
  - The write commits on the strobe cycle.
  - Read data is registered and valid with ack.
- A video-port read and a same-cycle bus write to the same cell returns the old data.
- Reset (asynchronous, any time):
  - RGB, `wb_ack_o` and `wb_dat_o` are 0.
  - The pipeline is flushed; RAM contents are undefined.
  - Outputs are black until 4 clk after release.

## Structure
- Shared package holds:
  - Region select codes.
  - Register offsets.
  - CTRL bit indices.
  - Cursor rows 6..7.
  - Intensity levels FF/AA/55/00.
  - The IRGB-to-RGB function.
- Sub-module `text_cell_ram`: single-clock, dual-port, COLS*ROWS × 16 (char + attr). Port A is video read; port B is bus read/write with byte selection of char or attr.
- Font lookup uses the existing `font_rom_8x8` (1-clk latency).

## Test plan
- Reset, no writes; active frame → RGB 000000 throughout; FRAME reads 0; CTRL reads 0x01.
- Write char 0x41, attr 0x1F at cell 0; drive pixel_x = 0..7, pixel_y = 0 → foreground pixels FFFFFF, others 0000AA, appearing 4 clk after each input.
- SCROLL = 1, write 0x42 at RAM row 1 col 0 → 'B' glyph at screen row 0. Write SCROLL = ROWS → readback still 1.
- cursor_en, CUR = (3,2), blink_en = 0 → pixel_y = 2*16+12..15 at cols 24..31 are fg; rows above are bg. With blink_en = 1, the cursor is absent for frames where FRAME[4] = 1.
- Attr 0x8F with blink_en → fg shown for FRAME 0–31, bg only for FRAME 32–63; bg is 000000 (no intensity).
- Bus: read offset COLS*ROWS → 0 with single-cycle ack; held strobe → ack toggles; reset asserted mid-transfer → ack 0 at once.
